// File: rtl/fmul_param.sv
// fmul_param: parametrised multi-cycle IEEE-754 multiplier with subnormals, four rounding modes and flags
module fmul_param #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  localparam int W = 1 + EXP_W + FRAC_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         Start,
  input  logic [1:0]   RoundMode,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  output logic [W-1:0] out,
  output logic         FBusy,
  output logic         Done,
  output logic         Invalid,
  output logic         Overflow,
  output logic         Underflow,
  output logic         Inexact
);
  localparam int M = FRAC_W + 1;
  localparam int P2 = 2 * M;
  localparam int EW = EXP_W + 2;
  localparam int LW = $clog2(P2) + 1;
  localparam int CW = $clog2(M + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d, tiny_q, tiny_d, stk_q, stk_d;
  logic [1:0] rm_q, rm_d;
  logic [M-1:0] ma_q, ma_d;
  logic [P2-1:0] prod_q, prod_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [W-1:0] out_q, out_d;
  logic [3:0] flg_q, flg_d;
  logic [EXP_W-1:0] ea, eb;
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, special, invalid, s_in, accept;
  logic [W-1:0] spec_res;
  logic signed [EW-1:0] e_in;
  logic [M:0] sum;
  logic [LW-1:0] lz, sh;
  logic [P2-1:0] pn;
  logic signed [EW-1:0] en, shs, ef;
  logic tiny;
  logic [M-1:0] m;
  logic [M:0] mr;
  logic g, st, inc, ovf, inx, to_inf;
  logic [W-1:0] rnd;
  // operand classification and special-case result, evaluated while idle
  always_comb begin
    ea = src1[W-2:FRAC_W];
    eb = src2[W-2:FRAC_W];
    nan_a = &ea & |src1[FRAC_W-1:0];
    nan_b = &eb & |src2[FRAC_W-1:0];
    inf_a = &ea & ~|src1[FRAC_W-1:0];
    inf_b = &eb & ~|src2[FRAC_W-1:0];
    zero_a = ~|ea & ~|src1[FRAC_W-1:0];
    zero_b = ~|eb & ~|src2[FRAC_W-1:0];
    special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
    invalid = (inf_a & zero_b) | (zero_a & inf_b);
    s_in = src1[W-1] ^ src2[W-1];
    spec_res = (nan_a | nan_b | invalid) ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}}
             : (inf_a | inf_b) ? {s_in, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} : {s_in, {(W-1){1'b0}}};
    e_in = EW'(~|ea ? EXP_W'(1) : ea) + EW'(~|eb ? EXP_W'(1) : eb) - EW'(BIAS);
    accept = (state_q == S_IDLE) & Start;
  end
  // shift-add step, leading-zero normalisation and subnormal denormalisation
  always_comb begin
    sum = {1'b0, prod_q[P2-1:M]} + (prod_q[0] ? {1'b0, ma_q} : '0);
    lz = '0;
    for (int i = 0; i < P2; i++) lz = prod_q[i] ? LW'(P2 - 1 - i) : lz;
    pn = prod_q << lz;
    en = exp_q + EW'(1) - EW'(lz);
    tiny = en[EW-1] | (en == '0);
    shs = EW'(1) - en;
    sh = (shs > EW'(M + 2)) ? LW'(M + 2) : LW'(shs);
  end
  // rounding, carry handling and overflow saturation
  always_comb begin
    m = prod_q[P2-1:M];
    g = prod_q[M-1];
    st = |prod_q[M-2:0] | stk_q;
    inc = (rm_q == 2'd0) ? g & (st | m[0]) : (rm_q == 2'd1) ? 1'b0 : (g | st) & (rm_q[0] ? sign_q : ~sign_q);
    mr = {1'b0, m} + {{M{1'b0}}, inc};
    ef = mr[M] ? exp_q + EW'(1) : tiny_q ? {{(EW-1){1'b0}}, mr[M-1]} : exp_q;
    ovf = ~ef[EW-1] & (ef[EW-2:0] >= (EW-1)'((1 << EXP_W) - 1));
    inx = g | st | ovf;
    to_inf = (rm_q == 2'd0) | (rm_q[1] & (rm_q[0] == sign_q));
    rnd = ovf ? (to_inf ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}})
        : {sign_q, ef[EXP_W-1:0], mr[M] ? mr[FRAC_W:1] : mr[FRAC_W-1:0]};
  end
  // next-state sequencing
  always_comb begin
    state_d = (state_q == S_IDLE) ? (Start ? (special ? S_DONE : S_MULT) : S_IDLE)
            : (state_q == S_MULT) ? ((cnt_q == CW'(M - 1)) ? S_NORM : S_MULT)
            : (state_q == S_NORM) ? S_ROUND
            : (state_q == S_ROUND) ? S_DONE : S_IDLE;
  end
  // datapath register updates per state
  always_comb begin
    cnt_d = (state_q == S_MULT) ? cnt_q + CW'(1) : '0;
    sign_d = accept ? s_in : sign_q;
    rm_d = accept ? RoundMode : rm_q;
    ma_d = accept ? {|ea, src1[FRAC_W-1:0]} : ma_q;
    prod_d = accept ? {{M{1'b0}}, |eb, src2[FRAC_W-1:0]}
           : (state_q == S_MULT) ? {sum, prod_q[M-1:1]}
           : (state_q == S_NORM) ? (tiny ? pn >> sh : pn) : prod_q;
    exp_d = accept ? e_in : (state_q == S_NORM) ? en : exp_q;
    tiny_d = (state_q == S_NORM) ? tiny : tiny_q;
    stk_d = (state_q == S_NORM) ? tiny & |(pn & ~({P2{1'b1}} << sh)) : stk_q;
    out_d = (accept & special) ? spec_res : (state_q == S_ROUND) ? rnd : out_q;
    flg_d = (accept & special) ? {invalid, 3'b000} : (state_q == S_ROUND) ? {1'b0, ovf, tiny_q & inx, inx} : flg_q;
  end
  // state and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sign_q <= 1'b0;
      tiny_q <= 1'b0;
      stk_q <= 1'b0;
      rm_q <= '0;
      ma_q <= '0;
      prod_q <= '0;
      exp_q <= '0;
      out_q <= '0;
      flg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sign_q <= sign_d;
      tiny_q <= tiny_d;
      stk_q <= stk_d;
      rm_q <= rm_d;
      ma_q <= ma_d;
      prod_q <= prod_d;
      exp_q <= exp_d;
      out_q <= out_d;
      flg_q <= flg_d;
    end
  end
  // handshake and result outputs
  always_comb begin
    FBusy = state_q != S_IDLE;
    Done = state_q == S_DONE;
    out = out_q;
    {Invalid, Overflow, Underflow, Inexact} = flg_q;
  end
endmodule
